hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the ID/EX operand/control register stage. Detects load-use hazards,
//  taken-branch flushes and multi-cycle memory stalls. Drives hold/bubble/flush controls into
//  the IF/ID and ID/EX registers and the forwarding selects into the EX operand muxes.
//  Times out hung memory accesses into a sticky error state.
// PARAMETERS
//  REG_AW       5   register-index width
//  MEM_TIMEOUT  16  max wait cycles for mem_ack before the error state (>=2)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  id_rs1       in   REG_AW  ID-stage source 1 index
//  id_rs2       in   REG_AW  ID-stage source 2 index
//  id_use_rs1   in   1       ID instruction reads rs1
//  id_use_rs2   in   1       ID instruction reads rs2
//  ex_rs1       in   REG_AW  EX-stage source 1 index
//  ex_rs2       in   REG_AW  EX-stage source 2 index
//  ex_rd        in   REG_AW  EX destination
//  ex_R         in   1       EX instruction is a memory read
//  ex_WE        in   1       EX instruction writes a register
//  branch_taken in   1       EX resolved a taken branch
//  mem_rd       in   REG_AW  MEM destination
//  mem_WE       in   1       MEM writes a register
//  mem_req      in   1       MEM stage has an R/W access in progress
//  mem_ack      in   1       memory completes access this cycle
//  wb_rd        in   REG_AW  WB destination
//  wb_WE        in   1       WB writes a register
//  stall_if     out  1       hold PC and IF/ID
//  flush_if     out  1       clear IF/ID to NOP
//  bubble_id    out  1       zero the control fields entering ID/EX (WE, W, R, demux_sel, alucode)
//  hold_ex      out  1       hold ID/EX and EX/MEM
//  fwd_a        out  2       EX operand A: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwd_b        out  2       EX operand B, same encoding
//  err          out  1       sticky memory-timeout flag
// BEHAVIOUR
//  - Reset: state=RUN, wait_cnt=0, err=0; all control outputs are forced 0 while rst_n=0.
//  - FSM states: RUN, MEM_WAIT, ERROR. Outputs are Mealy (combinational from state+inputs);
//    err is registered.
//  - RUN priority, highest first:
//    1. mem_req & !mem_ack: stall_if=hold_ex=1 this cycle; next state MEM_WAIT, wait_cnt<=1.
//    2. branch_taken: flush_if=1, bubble_id=1 for exactly this cycle; load-use is ignored.
//    3. load-use: ex_R & ex_WE & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 &
//       id_rs2==ex_rd)) -> stall_if=1, bubble_id=1 for one cycle (hold_ex=0).
//    mem_req & mem_ack in the same cycle = zero-wait access; no stall.
//  - MEM_WAIT: stall_if=hold_ex=1 and branch_taken is ignored (EX is held stable).
//    - On mem_ack: all holds drop in that same cycle; next state RUN, wait_cnt<=0.
//    - Otherwise wait_cnt increments. When wait_cnt==MEM_TIMEOUT-1 without ack: next state
//      ERROR, err<=1.
//  - ERROR: stall_if=hold_ex=1 permanently. mem_ack is ignored. Exit only via rst_n.
//  - Forwarding (combinational, every state):
//    - fwd_a=10 if mem_WE & mem_rd!=0 & mem_rd==ex_rs1;
//    - else 01 if wb_WE & wb_rd!=0 & wb_rd==ex_rs1;
//    - else 00. fwd_b is identical using ex_rs2. EX/MEM beats MEM/WB when both match.
//  - Reset asserted mid-MEM_WAIT: the FSM returns to RUN immediately and counters clear.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - Adds output stall_cycles[31:0], reset 0.
//   - Increments on every clock with stall_if=1 and saturates at 32'hFFFFFFFF.
//  Undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  1. ex_R=1,ex_WE=1,ex_rd=3; id_rs1=3,id_use_rs1=1 -> stall_if=1,bubble_id=1 one cycle,
//     hold_ex=0.
//  2. Same as 1 with branch_taken=1 -> flush_if=1,bubble_id=1,stall_if=0.
//  3. mem_req=1, ack 3 cycles later -> stall_if=hold_ex=1 for 3 cycles, 0 in the ack cycle;
//     state back to RUN.
//  4. mem_req=1 with no ack, MEM_TIMEOUT=16 -> err=1 after 16 cycles; holds stay asserted
//     until rst_n pulse.
//  5. mem_rd=wb_rd=ex_rs1=7, mem_WE=wb_WE=1 -> fwd_a=10; same with rd=0 -> fwd_a=00.
//  6. rst_n low during MEM_WAIT -> all outputs 0 asynchronously; RUN on release. With
//     HAZARD_PERF_CNT_EN, stall_cycles counts the stall cycles of test 3 (=3).

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID/EX pipeline sequencer.
// Detects load-use hazards, taken-branch flushes and multi-cycle memory stalls.
// Drives the hold, bubble and flush controls and the EX operand forwarding selects.
// A memory access that never acknowledges is timed out into a sticky error state.
// Optional build macro HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter
// on the stall_cycles output.
module hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_R,
   input  logic              ex_WE,
   input  logic              branch_taken,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_WE,
   input  logic              mem_req,
   input  logic              mem_ack,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_WE,
   output logic              stall_if,
   output logic              flush_if,
   output logic              bubble_id,
   output logic              hold_ex,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] ERROR    = 2'd2;

   localparam int CW = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] next_cnt;
   logic          set_err;
   logic          stall_c;
   logic          flush_c;
   logic          bubble_c;
   logic          hold_c;
   logic          load_use;

   // EX/MEM result has priority over MEM/WB; register 0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
      if (mem_WE && (mem_rd != '0) && (mem_rd == rs))
         return 2'b10;
      else if (wb_WE && (wb_rd != '0) && (wb_rd == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign load_use = ex_R && ex_WE && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   // Next-state logic and Mealy hazard controls, prioritised memory > branch > load-use.
   always_comb begin
      next_state = state;
      next_cnt   = wait_cnt;
      set_err    = 1'b0;
      stall_c    = 1'b0;
      flush_c    = 1'b0;
      bubble_c   = 1'b0;
      hold_c     = 1'b0;
      case (state)
         RUN: begin
            if (mem_req && !mem_ack) begin
               stall_c    = 1'b1;
               hold_c     = 1'b1;
               next_state = MEM_WAIT;
               next_cnt   = CW'(1);
            end else if (branch_taken) begin
               flush_c  = 1'b1;
               bubble_c = 1'b1;
            end else if (load_use) begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               next_state = RUN;
               next_cnt   = '0;
            end else begin
               stall_c = 1'b1;
               hold_c  = 1'b1;
               if (wait_cnt == LAST_WAIT) begin
                  next_state = ERROR;
                  set_err    = 1'b1;
               end else begin
                  next_cnt = wait_cnt + CW'(1);
               end
            end
         end
         ERROR: begin
            stall_c = 1'b1;
            hold_c  = 1'b1;
         end
         default: begin
            next_state = RUN;
            next_cnt   = '0;
         end
      endcase
   end

   // State and wait counter; reset returns to RUN immediately, even mid-access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_cnt;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if (set_err)
         err <= 1'b1;
   end

   assign stall_if  = rst_n & stall_c;
   assign flush_if  = rst_n & flush_c;
   assign bubble_id = rst_n & bubble_c;
   assign hold_ex   = rst_n & hold_c;
   assign fwd_a     = rst_n ? fwd_sel(ex_rs1) : 2'b00;
   assign fwd_b     = rst_n ? fwd_sel(ex_rs2) : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
   // Saturating count of clocks spent with the front end stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (stall_if && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// behavioural model of the pipeline sequencing rules.
module tb_hazard_ctrl;

   localparam int REG_AW      = 5;
   localparam int MEM_TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic              id_use_rs1, id_use_rs2, ex_R, ex_WE, branch_taken;
   logic              mem_WE, mem_req, mem_ack, wb_WE;
   logic              stall_if, flush_if, bubble_id, hold_ex, err;
   logic [1:0]        fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]       stall_cycles;
`endif

   int checkCount = 0;
   int passCount  = 0;

   // Model state: whether an access is outstanding, how many cycles it has
   // stalled so far, whether it has hung, and total stalled clocks.
   bit          mWait;
   int          mStalled;
   bit          mErr;
   logic [31:0] mStalls;

   logic       eStall, eFlush, eBubble, eHold;
   logic [1:0] eFa, eFb;

   hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_R(ex_R), .ex_WE(ex_WE),
      .branch_taken(branch_taken),
      .mem_rd(mem_rd), .mem_WE(mem_WE), .mem_req(mem_req), .mem_ack(mem_ack),
      .wb_rd(wb_rd), .wb_WE(wb_WE),
      .stall_if(stall_if), .flush_if(flush_if), .bubble_id(bubble_id), .hold_ex(hold_ex),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .err(err)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
   endtask

   function automatic logic [1:0] expFwd(input logic [REG_AW-1:0] rs);
      if (mem_WE && mem_rd != 0 && mem_rd == rs) return 2'b10;
      if (wb_WE && wb_rd != 0 && wb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit loadUse();
      return ex_R && ex_WE && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
   endfunction

   task automatic computeExpected();
      {eStall, eFlush, eBubble, eHold} = 4'b0000;
      eFa = 2'b00;
      eFb = 2'b00;
      if (rst_n) begin
         eFa = expFwd(ex_rs1);
         eFb = expFwd(ex_rs2);
         if (mErr) begin
            eStall = 1'b1; eHold = 1'b1;
         end else if (mWait) begin
            eStall = !mem_ack; eHold = !mem_ack;
         end else if (mem_req && !mem_ack) begin
            eStall = 1'b1; eHold = 1'b1;
         end else if (branch_taken) begin
            eFlush = 1'b1; eBubble = 1'b1;
         end else if (loadUse()) begin
            eStall = 1'b1; eBubble = 1'b1;
         end
      end
   endtask

   task automatic checkAll();
      computeExpected();
      checkOutput("stall_if", 32'(stall_if), 32'(eStall));
      checkOutput("flush_if", 32'(flush_if), 32'(eFlush));
      checkOutput("bubble_id", 32'(bubble_id), 32'(eBubble));
      checkOutput("hold_ex", 32'(hold_ex), 32'(eHold));
      checkOutput("fwd_a", 32'(fwd_a), 32'(eFa));
      checkOutput("fwd_b", 32'(fwd_b), 32'(eFb));
      checkOutput("err", 32'(err), 32'(mErr));
`ifdef HAZARD_PERF_CNT_EN
      checkOutput("stall_cycles", stall_cycles, mStalls);
`endif
   endtask

   // Advance the model across one rising edge using the inputs that were applied.
   task automatic updateModel();
      computeExpected();
      if (eStall && mStalls != 32'hFFFF_FFFF) mStalls = mStalls + 32'd1;
      if (mErr) begin
      end else if (mWait) begin
         if (mem_ack) begin
            mWait = 1'b0;
            mStalled = 0;
         end else begin
            mStalled++;
            if (mStalled == MEM_TIMEOUT) mErr = 1'b1;
         end
      end else if (mem_req && !mem_ack) begin
         mWait = 1'b1;
         mStalled = 1;
      end
   endtask

   // Called just after a falling edge with inputs set: check, clock, return at next falling edge.
   task automatic applyStimulus();
      #1 checkAll();
      @(posedge clk);
      updateModel();
      @(negedge clk);
   endtask

   task automatic setIdle();
      {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
      {id_use_rs1, id_use_rs2, ex_R, ex_WE, branch_taken} = '0;
      {mem_WE, mem_req, mem_ack, wb_WE} = '0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      mWait = 1'b0; mStalled = 0; mErr = 1'b0; mStalls = '0;
      #1 checkAll();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic randomizeInputs();
      id_rs1 = REG_AW'($urandom_range(0, 3));
      id_rs2 = REG_AW'($urandom_range(0, 3));
      ex_rs1 = REG_AW'($urandom_range(0, 3));
      ex_rs2 = REG_AW'($urandom_range(0, 3));
      ex_rd  = REG_AW'($urandom_range(0, 3));
      mem_rd = REG_AW'($urandom_range(0, 3));
      wb_rd  = REG_AW'($urandom_range(0, 3));
      id_use_rs1   = ($urandom_range(0, 1) == 1);
      id_use_rs2   = ($urandom_range(0, 1) == 1);
      ex_R         = ($urandom_range(0, 1) == 1);
      ex_WE        = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      mem_WE       = ($urandom_range(0, 1) == 1);
      wb_WE        = ($urandom_range(0, 1) == 1);
      mem_req      = ($urandom_range(0, 5) == 0);
      mem_ack      = ($urandom_range(0, 3) == 0);
   endtask

   initial begin
      setIdle();
      doReset();

      // Load-use stall, then the same hazard overridden by a taken branch.
      ex_R = 1'b1; ex_WE = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
      #1;
      checkOutput("t1_stall", 32'(stall_if), 32'd1);
      checkOutput("t1_bubble", 32'(bubble_id), 32'd1);
      checkOutput("t1_hold", 32'(hold_ex), 32'd0);
      applyStimulus();
      branch_taken = 1'b1;
      #1;
      checkOutput("t2_flush", 32'(flush_if), 32'd1);
      checkOutput("t2_bubble", 32'(bubble_id), 32'd1);
      checkOutput("t2_stall", 32'(stall_if), 32'd0);
      applyStimulus();

      // Forwarding priorities and the register-0 exclusion.
      setIdle();
      mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_WE = 1'b1; wb_WE = 1'b1;
      #1 checkOutput("t5_fwd_mem", 32'(fwd_a), 32'd2);
      applyStimulus();
      mem_WE = 1'b0;
      #1 checkOutput("t5_fwd_wb", 32'(fwd_b), 32'd1);
      applyStimulus();
      mem_WE = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
      #1 checkOutput("t5_fwd_r0", 32'(fwd_a), 32'd0);
      applyStimulus();

      // Memory access acknowledged three cycles after the request.
      setIdle();
      doReset();
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 checkOutput("t3_wait_stall", 32'(stall_if & hold_ex), 32'd1);
         applyStimulus();
      end
      mem_ack = 1'b1;
      #1 checkOutput("t3_ack_stall", 32'(stall_if | hold_ex), 32'd0);
      applyStimulus();
      setIdle();
      #1 checkOutput("t3_run", 32'(stall_if), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      checkOutput("t3_stall_cycles", stall_cycles, 32'd3);
`endif
      applyStimulus();

      // Hung access times out into the sticky error state.
      mem_req = 1'b1;
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         #1 checkOutput("t4_err_early", 32'(err), 32'd0);
         applyStimulus();
      end
      #1 checkOutput("t4_err", 32'(err), 32'd1);
      mem_ack = 1'b1; branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 checkOutput("t4_hold", 32'(stall_if & hold_ex), 32'd1);
         applyStimulus();
      end

      // Reset mid-wait: outputs drop asynchronously, RUN afterwards.
      setIdle();
      doReset();
      mem_req = 1'b1;
      applyStimulus();
      applyStimulus();
      ex_rs1 = 5'd2; mem_rd = 5'd2; mem_WE = 1'b1;
      doReset();
      checkOutput("t6_stall_rst", 32'(stall_if | hold_ex), 32'd0);
      checkOutput("t6_fwd_rst", 32'(fwd_a), 32'd0);
      mem_req = 1'b0;
      #1 checkOutput("t6_run", 32'(stall_if), 32'd0);
      applyStimulus();

      // Randomized traffic with periodic resets.
      for (int n = 0; n < 2000; n++) begin
         if (n % 300 == 299) doReset();
         randomizeInputs();
         applyStimulus();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
